// File: rtl/booth_mult32_pkg.sv
// mult_pkg: shared state encoding, iteration count and Booth select codes for booth_mult32
package mult_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int ITER      = WIDTH_DEF / 2;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        PM,
        P2M,
        NM,
        N2M
    } booth_sel_e;

    // Radix-4 Booth recoding of the triple {q[i+1], q[i], q[i-1]}
    function automatic booth_sel_e booth_sel(input logic [2:0] t);
        case (t)
            3'b001, 3'b010: return PM;
            3'b011:         return P2M;
            3'b100:         return N2M;
            3'b101, 3'b110: return NM;
            default:        return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_recode.sv
// booth_recode: maps a Booth triple and multiplicand to the sign-extended partial-product addend
module booth_recode
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       i_triple,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH+1:0] o_addend
);

    booth_sel_e       w_sel;
    logic [WIDTH+1:0] w_m1;
    logic [WIDTH+1:0] w_m2;

    assign w_sel = booth_sel(i_triple);
    // Two guard bits keep 2M and -2M exact, including for the most negative M
    assign w_m1  = {{2{i_m[WIDTH-1]}}, i_m};
    assign w_m2  = {w_m1[WIDTH:0], 1'b0};

    // Select the addend from the recoded digit
    always_comb begin
        o_addend = w_sel == PM  ? w_m1 :
                   w_sel == P2M ? w_m2 :
                   w_sel == NM  ? -w_m1 :
                   w_sel == N2M ? -w_m2 : '0;
    end

endmodule

// File: rtl/booth_mult32.sv
// booth_mult32: multi-cycle signed multiplier, radix-4 Booth, low-half result plus overflow flag
module booth_mult32
    import mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int N_ITER = WIDTH / 2;
    localparam int CW     = $clog2(N_ITER) + 1;
    localparam int PW     = 2 * WIDTH + 3;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_m;
    logic [PW-1:0]    r_p;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_exc;
    logic [WIDTH+1:0] w_addend;
    logic [WIDTH+1:0] w_h_new;
    logic [PW-1:0]    w_p_next;
    logic [WIDTH:0]   w_hi;
    logic             w_last;
    logic             w_exc;

    booth_recode #(.WIDTH(WIDTH)) u_recode (
        .i_triple (r_p[2:0]),
        .i_m      (r_m),
        .o_addend (w_addend)
    );

    // P = {H, L, q_m1}: add into H, then arithmetic shift right by two
    assign w_h_new  = r_p[PW-1:WIDTH+1] + w_addend;
    assign w_p_next = {{2{w_h_new[WIDTH+1]}}, w_h_new, r_p[WIDTH:2]};
    // Product bits [2W-1:W-1] all equal means the product fits in WIDTH signed bits
    assign w_hi     = w_p_next[2*WIDTH:WIDTH];
    assign w_exc    = !((&w_hi) || !(|w_hi));
    assign w_last   = (r_state == BUSY) && (r_cnt == CW'(N_ITER - 1));

    assign data_result    = r_result;
    assign data_exception = r_exc;
    assign data_resultRDY = (r_state == DONE);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next state: a start wins over everything, DONE lasts one cycle
    always_comb begin
        w_state_next = r_state;
        w_state_next = ctrl_MULT            ? BUSY :
                       w_last               ? DONE :
                       (r_state == DONE)    ? IDLE : r_state;
    end

    // Datapath: load operands on start, iterate while busy, latch outputs on the last step
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_m      <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (ctrl_MULT) begin
            r_m      <= data_operandA;
            r_p      <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (r_state == BUSY) begin
            r_p   <= w_p_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_result <= w_p_next[WIDTH:1];
                r_exc    <= w_exc;
            end
        end
    end

endmodule

// File: tb/tb_booth_mult32.sv
// tb_booth_mult32: directed and random scoreboard bench for booth_mult32
module tb_booth_mult32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    int n_checks = 0;
    int n_err = 0;
    logic [32:0] sb[$];

    booth_mult32 #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] p;
        logic ovf;
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        ovf = (p < -64'sd2147483648) || (p > 64'sd2147483647);
        return {ovf, p[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = 1'b1;
        data_operandA = a;
        data_operandB = b;
        sb.delete();
        sb.push_back(model(a, b));
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic finish_op(input string tag);
        int n;
        logic seen;
        logic [32:0] exp;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            seen = data_resultRDY;
        end
        chk({tag, "_latency"}, 64'(n), 64'd16);
        exp = (sb.size() > 0) ? sb.pop_front() : 33'h0;
        chk({tag, "_result"}, 64'(data_result), 64'(exp[31:0]));
        chk({tag, "_exc"}, 64'(data_exception), 64'(exp[32]));
        @(posedge clock);
        #1;
        chk({tag, "_rdy_low"}, 64'(data_resultRDY), 64'd0);
        chk({tag, "_hold"}, 64'({data_exception, data_result}), 64'(exp));
    endtask

    initial begin
        logic [31:0] special[6];
        logic [31:0] a;
        logic [31:0] b;
        int rdy_seen;
        special[0] = 32'h0000_0000;
        special[1] = 32'h0000_0001;
        special[2] = 32'hFFFF_FFFF;
        special[3] = 32'h8000_0000;
        special[4] = 32'h7FFF_FFFF;
        special[5] = 32'h0000_0002;
        #1;
        chk("reset_result", 64'(data_result), 64'd0);
        chk("reset_exc", 64'(data_exception), 64'd0);
        chk("reset_rdy", 64'(data_resultRDY), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        start_op(32'd3, 32'd5);
        chk("busy_result_clear", 64'(data_result), 64'd0);
        finish_op("m3x5");
        chk("m3x5_const", 64'(data_result), 64'h0000_000F);

        start_op(32'hFFFF_FFF9, 32'd6);
        finish_op("m_7x6");
        chk("m_7x6_const", 64'(data_result), 64'hFFFF_FFD6);
        start_op(32'h8000_0000, 32'd1);
        finish_op("minx1");
        start_op(32'h0001_0000, 32'h0001_0000);
        finish_op("ovf16");
        chk("ovf16_const", 64'(data_exception), 64'd1);
        start_op(32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("minxm1");
        chk("minxm1_const", 64'({data_exception, data_result}), 64'h1_8000_0000);

        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_result", 64'(data_result), 64'd0);
        chk("async_rst_exc", 64'(data_exception), 64'd0);
        @(negedge clock);
        reset = 1'b0;

        start_op(32'd2, 32'd2);
        for (int i = 0; i < 4; i++) begin
            @(posedge clock);
            #1;
        end
        start_op(32'd4, 32'd9);
        finish_op("abort");
        chk("abort_const", 64'(data_result), 64'h0000_0024);

        start_op(32'd100, 32'd100);
        for (int i = 0; i < 7; i++) begin
            @(posedge clock);
            #1;
        end
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("midop_rst_rdy", 64'(data_resultRDY), 64'd0);
        chk("midop_rst_result", 64'(data_result), 64'd0);
        chk("midop_rst_exc", 64'(data_exception), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) rdy_seen++;
        end
        chk("no_rdy_after_rst", 64'(rdy_seen), 64'd0);
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("m1xm1");
        chk("m1xm1_const", 64'({data_exception, data_result}), 64'h0_0000_0001);

        for (int i = 0; i < 1000; i++) begin
            a = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
            start_op(a, b);
            finish_op("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
